// File: rtl/intpol2_ramp_accum.sv
// intpol2_ramp_accum
//   Multi-channel ramp generator for the IntPol2 interpolator datapath.
//   Each accepted start launches a segment of STEPS = 2**STEP_W samples per
//   channel, y = base + k*incr for k = 0..STEPS-1. The samples are built by
//   repeated addition. Back-to-back segments run with no bubble. The output
//   uses ready/valid with backpressure.
//
//   Optional feature: define INTPOL2_RAMP_SAT_EN to make every channel add a
//   signed saturating add. Without it, the add wraps modulo 2**W.
//
// Ports
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   clear      synchronous clear; same effect as reset, highest priority
//   start      request a new segment
//   base       per-channel start values, channel c at [c*W +: W]
//   incr       per-channel increments, same packing
//   busy       high while a segment is running
//   out_valid  y/step/last hold a valid sample
//   out_ready  downstream accepts the sample (beat = out_valid & out_ready)
//   y          per-channel sample, registered
//   step       index k of the current sample
//   last       high with the final sample of a segment
//   done       one-cycle pulse after a final beat that has no follow-on segment

module intpol2_ramp_accum #(
    parameter int DATAPATH_WIDTH = 32,
    parameter int N_bits         = 2,
    parameter int NCH            = 2,
    parameter int STEP_W         = 2
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     clear,
    input  logic                                     start,
    input  logic [NCH*(DATAPATH_WIDTH+N_bits)-1:0]   base,
    input  logic [NCH*(DATAPATH_WIDTH+N_bits)-1:0]   incr,
    output logic                                     busy,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [NCH*(DATAPATH_WIDTH+N_bits)-1:0]   y,
    output logic [STEP_W-1:0]                        step,
    output logic                                     last,
    output logic                                     done
);

    localparam int W = DATAPATH_WIDTH + N_bits;
    localparam logic [STEP_W-1:0] LAST_STEP = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [W-1:0]       acc   [NCH];
    logic [W-1:0]       inc_q [NCH];
    logic [STEP_W-1:0]  cnt;

    logic beat;
    logic final_beat;
    logic accept;

    // One channel's add. With saturation, overflow is detected when the two
    // operands share a sign and the sum flips it. The sum then clamps towards
    // the operands' sign.
    function automatic logic [W-1:0] ch_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
`ifdef INTPOL2_RAMP_SAT_EN
        if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]))
            s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return s;
    endfunction

    assign beat       = out_valid & out_ready;
    assign final_beat = beat & (cnt == LAST_STEP);
    // In RUN, a start is taken only on the beat of the final sample. Any
    // other start is dropped, not queued.
    assign accept     = start & ((state == IDLE) | final_beat);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                acc[c]   <= '0;
                inc_q[c] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                cnt       <= '0;
                out_valid <= 1'b0;
                for (int unsigned c = 0; c < NCH; c++) begin
                    acc[c]   <= '0;
                    inc_q[c] <= '0;
                end
            end else if (accept) begin
                state     <= RUN;
                cnt       <= '0;
                out_valid <= 1'b1;
                for (int unsigned c = 0; c < NCH; c++) begin
                    acc[c]   <= base[c*W +: W];
                    inc_q[c] <= incr[c*W +: W];
                end
            end else if ((state == RUN) && beat) begin
                if (final_beat) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    for (int unsigned c = 0; c < NCH; c++)
                        acc[c] <= ch_add(acc[c], inc_q[c]);
                end
            end
        end
    end

    always_comb begin
        y = '0;
        for (int unsigned c = 0; c < NCH; c++)
            y[c*W +: W] = acc[c];
    end

    assign step = cnt;
    assign last = out_valid & (cnt == LAST_STEP);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_intpol2_ramp_accum.sv
// Bench for intpol2_ramp_accum: directed scenarios with literal expectations,
// then a randomized phase. A segment-level reference model supplies the
// expected outputs. It computes each sample directly as base + k*incr,
// either wrapped or clamped.

module tb_intpol2_ramp_accum;

    localparam int DW    = 32;
    localparam int NB    = 2;
    localparam int NCH   = 2;
    localparam int SW    = 2;
    localparam int W     = DW + NB;
    localparam int STEPS = 1 << SW;

    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic [NCH*W-1:0]  base = '0;
    logic [NCH*W-1:0]  incr = '0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [NCH*W-1:0]  y;
    logic [SW-1:0]     step;
    logic              last;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    intpol2_ramp_accum #(
        .DATAPATH_WIDTH(DW),
        .N_bits(NB),
        .NCH(NCH),
        .STEP_W(SW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .clear(clear),
        .start(start),
        .base(base),
        .incr(incr),
        .busy(busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y(y),
        .step(step),
        .last(last),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'({{(64-W){v[W-1]}}, v});
    endfunction

    function automatic logic [63:0] wbits(input longint v);
        logic [63:0] r;
        r = '0;
        r[W-1:0] = v[W-1:0];
        return r;
    endfunction

    // ---------------- reference model (segment level) ----------------
    longint m_base [NCH];
    longint m_inc  [NCH];
    int     m_k;
    bit     m_active;
    bit     m_done;
    bit     m_zero;

    function automatic logic [63:0] exp_y(input int c);
        longint v;
        v = m_base[c] + longint'(m_k) * m_inc[c];
`ifdef INTPOL2_RAMP_SAT_EN
        if (v > MAXV) v = MAXV;
        if (v < MINV) v = MINV;
`endif
        return wbits(v);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b0;
            m_zero   <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (clear) begin
                m_active <= 1'b0;
                m_k      <= 0;
                m_zero   <= 1'b1;
            end else if (start && (!m_active || (out_ready && m_k == STEPS-1))) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_zero   <= 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    m_base[c] <= sx(base[c*W +: W]);
                    m_inc[c]  <= sx(incr[c*W +: W]);
                end
            end else if (m_active && out_ready) begin
                if (m_k < STEPS-1) begin
                    m_k <= m_k + 1;
                end else begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_active});
            chk("busy", {63'd0, busy}, {63'd0, m_active});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("last", {63'd0, last}, {63'd0, (m_active && m_k == STEPS-1)});
            if (m_active) begin
                chk("step", {{(64-SW){1'b0}}, step}, 64'(m_k));
                for (int c = 0; c < NCH; c++)
                    chk("y", {{(64-W){1'b0}}, y[c*W +: W]}, exp_y(c));
            end else if (m_zero) begin
                chk("step_zero", {{(64-SW){1'b0}}, step}, 64'd0);
                chk("y_zero", {{(64-W){1'b0}}, y}, 64'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_seg(input longint b0, input longint i0, input longint b1, input longint i1);
        base[0*W +: W] = b0[W-1:0];
        incr[0*W +: W] = i0[W-1:0];
        base[1*W +: W] = b1[W-1:0];
        incr[1*W +: W] = i1[W-1:0];
    endtask

    function automatic logic [63:0] ych(input int c);
        return {{(64-W){1'b0}}, y[c*W +: W]};
    endfunction

    // Scenario 1: base 10, incr 3, out_ready held high.
    task automatic seg_basic();
        out_ready = 1'b1;
        set_seg(10, 3, 50, -7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < STEPS; k++) begin
            chk("s1_y", ych(0), 64'(10 + 3*k));
            chk("s1_y1", ych(1), wbits(50 - 7*k));
            chk("s1_step", {{(64-SW){1'b0}}, step}, 64'(k));
            chk("s1_last", {63'd0, last}, {63'd0, (k == STEPS-1)});
            @(negedge clk);
        end
        chk("s1_done", {63'd0, done}, 64'd1);
        chk("s1_valid_off", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("s1_done_pulse", {63'd0, done}, 64'd0);
        chk("s1_busy_off", {63'd0, busy}, 64'd0);
    endtask

    logic [63:0] r;

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_y", {{(64-W){1'b0}}, y}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        seg_basic();

        // Scenario 2: backpressure while y = 13
        set_seg(10, 3, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("s2_hold_y", ych(0), 64'd13);
            chk("s2_hold_step", {{(64-SW){1'b0}}, step}, 64'd1);
            chk("s2_hold_last", {63'd0, last}, 64'd0);
            if (i == 2) out_ready = 1'b1;
            @(negedge clk);
        end
        chk("s2_y16", ych(0), 64'd16);
        @(negedge clk);
        chk("s2_y19", ych(0), 64'd19);
        @(negedge clk);
        chk("s2_done", {63'd0, done}, 64'd1);
        @(negedge clk);

        // Scenario 3: back-to-back reload, ch1 incr -5
        set_seg(10, 3, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (STEPS-1) @(negedge clk);
        chk("s3_last", {63'd0, last}, 64'd1);
        set_seg(100, 2, 100, -5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < STEPS; k++) begin
            chk("s3_y1", ych(1), 64'(100 - 5*k));
            chk("s3_y0", ych(0), 64'(100 + 2*k));
            chk("s3_no_done", {63'd0, done}, 64'd0);
            chk("s3_valid", {63'd0, out_valid}, 64'd1);
            @(negedge clk);
        end
        chk("s3_done", {63'd0, done}, 64'd1);
        @(negedge clk);

        // Scenario 4: overflow at the positive and negative extremes
        set_seg(MAXV, 1, MINV, -1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s4_y0", ych(0), wbits(MAXV));
        @(negedge clk);
`ifdef INTPOL2_RAMP_SAT_EN
        chk("s4_y1_pos", ych(0), wbits(MAXV));
        chk("s4_y1_neg", ych(1), wbits(MINV));
        @(negedge clk);
        @(negedge clk);
        chk("s4_y3_pos", ych(0), wbits(MAXV));
`else
        chk("s4_y1_pos", ych(0), wbits(MINV));
        chk("s4_y1_neg", ych(1), wbits(MAXV));
        @(negedge clk);
        @(negedge clk);
        chk("s4_y3_pos", ych(0), wbits(MINV + 2));
`endif
        repeat (2) @(negedge clk);

        // Scenario 5: start at step 1 and mid-run incr change are ignored
        set_seg(10, 3, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        set_seg(500, 50, 500, 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("s5_y2", ych(0), 64'd16);
        chk("s5_step2", {{(64-SW){1'b0}}, step}, 64'd2);
        @(negedge clk);
        chk("s5_y3", ych(0), 64'd19);
        @(negedge clk);
        chk("s5_done", {63'd0, done}, 64'd1);
        @(negedge clk);

        // Scenario 6a: synchronous clear at step 2
        set_seg(10, 3, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("s6_clr_valid", {63'd0, out_valid}, 64'd0);
        chk("s6_clr_y", {{(64-W){1'b0}}, y}, 64'd0);
        chk("s6_clr_busy", {63'd0, busy}, 64'd0);
        chk("s6_clr_done", {63'd0, done}, 64'd0);

        // Scenario 6b: asynchronous reset at step 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("s6_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("s6_rst_y", {{(64-W){1'b0}}, y}, 64'd0);
        chk("s6_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        seg_basic();

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            start     = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NCH; c++) begin
                r = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0)
                    r = $urandom_range(0, 1) ? MAXV : MINV;
                base[c*W +: W] = r[W-1:0];
                r = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0)
                    r = 64'($signed($urandom_range(0, 64)) - 32);
                incr[c*W +: W] = r[W-1:0];
            end
            @(negedge clk);
        end
        start = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        repeat (STEPS + 2) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/intpol2_ramp_accum.md
# intpol2_ramp_accum

Multi-channel ramp generator for the IntPol2 interpolator datapath. It produces a segment of STEPS evenly spaced samples per channel, base + k·incr for k = 0..STEPS-1, by repeated addition instead of multiplication. It adds a start/done handshake, a ready/valid output with backpressure, back-to-back segments, and optional saturation. It sits between the coefficient stage (which supplies base and incr) and the output sample path.

## Interface
- DATAPATH_WIDTH, 32, fractional/data width of each channel value
- N_bits, 2, integer guard bits; channel width W = DATAPATH_WIDTH+N_bits, two's complement
- NCH, 2, number of channels sharing one step counter and one handshake
- STEP_W, 2, log2 of steps per segment; STEPS = 2^STEP_W (4 → D4 interpolation)

- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear; same effect as reset, takes priority over all other inputs
- start  in  1  request a new segment; accepted per rules below
- base  in  NCH*W  per-channel segment start value, channel c at [c*W +: W]; sampled on accepted start
- incr  in  NCH*W  per-channel increment, same packing; sampled on accepted start
- busy  out  1  high while state is RUN
- out_valid  out  1  y holds a valid step sample
- out_ready  in  1  downstream accepts the sample; beat = out_valid & out_ready
- y  out  NCH*W  per-channel sample, registered
- step  out  STEP_W  index k of the current sample
- last  out  1  high with the sample where step == STEPS-1
- done  out  1  one-cycle pulse on the cycle after the final beat when no new segment follows

## Operation
- States: IDLE, RUN. Internal registers: acc[NCH] (drives y), inc_q[NCH], cnt (drives step).
- Reset or clear: state IDLE; y=0, step=0, out_valid=0, last=0, busy=0, done=0; inc_q=0.
- Start is accepted when state is IDLE, or in RUN on the beat of the last sample (back-to-back).
  - On acceptance: acc←base, inc_q←incr, cnt←0, state RUN, out_valid←1.
- Start is ignored in RUN on non-final beats and when no beat occurs. It is not queued.
- RUN, beat with cnt < STEPS-1: acc[c]←acc[c]+inc_q[c] for every channel, cnt←cnt+1.
- RUN, beat with cnt == STEPS-1:
  - with start: reload as above, with no bubble;
  - without start: state IDLE, out_valid←0, done←1 for one cycle.
- RUN without a beat: all registers hold, so y, step and last are stable under backpressure.
- last = out_valid & (cnt == STEPS-1); busy = (state == RUN).
- Arithmetic: W-bit two's complement, with wrap-around modulo 2^W unless the saturation macro is defined. inc_q changes only on accepted start, so a new incr in mid-segment has no effect.
- Asserting start and clear together: clear wins and start is dropped.

## Timing
- Start accepted at edge t → out_valid=1 and y=base at t+1 (one cycle latency).
- With out_ready held at 1: one sample per cycle, and the segment occupies STEPS consecutive cycles.
- Sample k appears at or after t+1+k, and equals base + k·incr (mod 2^W, or saturated).
- Final beat at edge u without start → done=1 and out_valid=0 during u+1. Earliest next accepted start is at u+1, with its first sample at u+2.
- Back-to-back: the next segment's base appears at u+1, so there is no idle cycle.
- rstn takes effect asynchronously; outputs go to their reset values immediately on assertion, even in mid-segment.

## Configuration
- INTPOL2_RAMP_SAT_EN defined: each channel add is a signed saturating add. On positive overflow the result clamps to 2^(W-1)-1; on negative overflow it clamps to -2^(W-1). Saturation is per channel and independent.
- Not defined: plain W-bit wrap-around add, with no extra logic.

## Test plan
- W=34, STEPS=4, base=10, incr=3, out_ready=1, start pulse → y=10,13,16,19 on consecutive cycles; step=0..3; last on 19; done on the next cycle; busy then low.
- Same stimulus, out_ready low for 2 cycles while y=13 → y, step=1 and last=0 are held for 3 cycles, then y resumes 16,19.
- Start held high with base=100 on the final beat, ch1 incr=-5 → y=100 on the very next cycle with no done pulse; ch1 then follows 100,95,90,85.
- base=2^33-1, incr=1 → without macro, step1 y = -2^33; with INTPOL2_RAMP_SAT_EN, y stays at 2^33-1 for steps 1..3.
- Start at step 1, then incr changed mid-run → both ignored; sequence unchanged.
- clear at step 2, then separately rstn low at step 2 → out_valid=0, y=0, busy=0 immediately (next edge for clear, asynchronously for rstn); a later start behaves as in scenario 1.
